// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter feeding a single registered commit entry
module wb_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int ID_WIDTH   = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_UNITS-1:0]                  unit_done,
    input  logic [NUM_UNITS-1:0][ID_WIDTH-1:0]    unit_id,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  unit_rd,
    output logic [NUM_UNITS-1:0]                  unit_ack,
    output logic                                  wb_valid,
    output logic [ID_WIDTH-1:0]                   wb_id,
    output logic [DATA_WIDTH-1:0]                 wb_data,
    input  logic                                  commit_ready,
    output logic [31:0]                           commit_count
);
    localparam int PW = $clog2(NUM_UNITS);

    logic [PW-1:0]         r_rr_ptr;
    logic                  r_wb_valid;
    logic [ID_WIDTH-1:0]   r_wb_id;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [31:0]           r_commit_count;
    logic                  w_load_en;
    logic                  w_found;
    logic [PW-1:0]         w_sel;
    logic [PW-1:0]         w_k;

    assign w_load_en    = ~r_wb_valid | commit_ready;
    assign unit_ack     = (w_found && w_load_en && !rst) ? (NUM_UNITS'(1) << w_sel) : '0;
    assign wb_valid     = r_wb_valid;
    assign wb_id        = r_wb_id;
    assign wb_data      = r_wb_data;
    assign commit_count = r_commit_count;

    // scan from rr_ptr downward in priority so the closest requester after rr_ptr wins
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_k     = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            w_k = PW'((32'(r_rr_ptr) + 32'(i)) % NUM_UNITS);
            if (unit_done[w_k]) begin
                w_found = 1'b1;
                w_sel   = w_k;
            end
        end
    end

    // output entry, round-robin pointer and commit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_id        <= '0;
            r_wb_data      <= '0;
            r_commit_count <= '0;
        end else begin
            if (r_wb_valid && commit_ready) r_commit_count <= r_commit_count + 32'd1;
            if (w_load_en) begin
                r_wb_valid <= w_found;
                if (w_found) begin
                    r_wb_id   <= unit_id[w_sel];
                    r_wb_data <= unit_rd[w_sel];
                    r_rr_ptr  <= (w_sel == PW'(NUM_UNITS - 1)) ? '0 : w_sel + 1'b1;
                end
            end
        end
    end
endmodule
